// File: rtl/nic_cpu_pkg.sv
// nic_cpu_pkg: shared types for the NIC control CPU.
// State enum, instruction field encodings, field positions.
package nic_cpu_pkg;

   typedef enum logic [2:0] {
      FETCH,
      OPND,
      MEMRD,
      EXEC,
      MEMWR,
      HALT
   } stateT;

   typedef enum logic [2:0] {
      SRC_IMM,
      SRC_RAM,
      SRC_ADD,
      SRC_SUB,
      SRC_A,
      SRC_B,
      SRC_X,
      SRC_Q
   } srcT;

   typedef enum logic [2:0] {
      DST_A,
      DST_B,
      DST_X,
      DST_Q,
      DST_RAM,
      DST_PC,
      DST_PCZ,
      DST_PCC
   } dstT;

   typedef enum logic [1:0] {
      MODE_NORM,
      MODE_HALT,
      MODE_OUT,
      MODE_NOP
   } modeT;

   localparam int SRC_HI  = 7;
   localparam int SRC_LO  = 5;
   localparam int DST_HI  = 4;
   localparam int DST_LO  = 2;
   localparam int MODE_HI = 1;
   localparam int MODE_LO = 0;

   function automatic srcT irSrc(input logic [7:0] ir);
      return srcT'(ir[SRC_HI:SRC_LO]);
   endfunction

   function automatic dstT irDst(input logic [7:0] ir);
      return dstT'(ir[DST_HI:DST_LO]);
   endfunction

   function automatic modeT irMode(input logic [7:0] ir);
      return modeT'(ir[MODE_HI:MODE_LO]);
   endfunction

endpackage

// File: rtl/nic_alu.sv
// nic_alu: combinational DW-bit adder/subtractor.
// Ports: a, b, sub in; y result, carry (add carry-out / sub no-borrow).
module nic_alu #(
   parameter int DW = 8
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic          sub,
   output logic [DW-1:0] y,
   output logic          carry
);

   logic [DW:0] sum;

   // a + ~b + 1 carries out exactly when a >= b
   assign sum   = {1'b0, a}
                + {1'b0, (sub ? ~b : b)}
                + {{DW{1'b0}}, sub};
   assign y     = sum[DW-1:0];
   assign carry = sum[DW];

endmodule

// File: rtl/nic_cpu_core.sv
// nic_cpu_core: tiny accumulator CPU, ROM program, RAM data, out port.
// Ports: clk/reset, rom_* fetch, ram_* data, out_*, halted, debug taps.
module nic_cpu_core
   import nic_cpu_pkg::*;
#(
   parameter int DW  = 8,
   parameter int AW  = 8,
   parameter int RAW = 8
) (
   input  logic           clk,
   input  logic           reset,
   output logic [AW-1:0]  rom_addr,
   input  logic [DW-1:0]  rom_data,
   input  logic           rom_valid,
   output logic [RAW-1:0] ram_addr,
   output logic [DW-1:0]  ram_wdata,
   output logic           ram_re,
   output logic           ram_we,
   input  logic [DW-1:0]  ram_rdata,
   input  logic           ram_ready,
   output logic [DW-1:0]  out_data,
   output logic           out_strobe,
   output logic           halted,
   output logic [AW-1:0]  pc_dbg,
   output logic [DW-1:0]  a_dbg
);

   stateT         state;
   stateT         stateNxt;
   logic [AW-1:0] pc;
   logic [7:0]    ir;
   logic [DW-1:0] a;
   logic [DW-1:0] b;
   logic [DW-1:0] x;
   logic [DW-1:0] q;
   logic          c;
   logic [DW-1:0] opnd;
   logic [DW-1:0] res;
   logic [DW-1:0] outData;

   srcT           src;
   dstT           dst;
   modeT          mode;
   srcT           fetchSrc;
   logic [DW-1:0] aluY;
   logic          aluC;
   logic [DW-1:0] result;
   logic [AW-1:0] pcTgt;

   assign src      = irSrc(ir);
   assign dst      = irDst(ir);
   assign mode     = irMode(ir);
   assign fetchSrc = irSrc(rom_data[7:0]);

   nic_alu #(
      .DW(DW)
   ) uAlu (
      .a    (a),
      .b    (b),
      .sub  (src == SRC_SUB),
      .y    (aluY),
      .carry(aluC)
   );

   always_comb begin
      result = opnd;
      unique case (src)
         SRC_IMM: result = opnd;
         SRC_RAM: result = opnd;
         SRC_ADD: result = aluY;
         SRC_SUB: result = aluY;
         SRC_A:   result = a;
         SRC_B:   result = b;
         SRC_X:   result = x;
         SRC_Q:   result = q;
      endcase
   end

   assign pcTgt = AW'(result);

   always_comb begin
      stateNxt = state;
      unique case (state)
         FETCH: begin
            if (rom_valid) begin
               unique case (fetchSrc)
                  SRC_IMM: stateNxt = OPND;
                  SRC_RAM: stateNxt = MEMRD;
                  default: stateNxt = EXEC;
               endcase
            end
         end
         OPND: begin
            if (rom_valid) stateNxt = EXEC;
         end
         MEMRD: begin
            if (ram_ready) stateNxt = EXEC;
         end
         EXEC: begin
            if (dst == DST_RAM && mode != MODE_NOP)
               stateNxt = MEMWR;
            else if (mode == MODE_HALT)
               stateNxt = HALT;
            else
               stateNxt = FETCH;
         end
         MEMWR: begin
            if (ram_ready)
               stateNxt = (mode == MODE_HALT) ? HALT : FETCH;
         end
         HALT:    stateNxt = HALT;
         default: stateNxt = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= FETCH;
         pc      <= '0;
         ir      <= '0;
         a       <= '0;
         b       <= '0;
         x       <= '0;
         q       <= '0;
         c       <= 1'b0;
         opnd    <= '0;
         res     <= '0;
         outData <= '0;
      end else begin
         state <= stateNxt;
         unique case (state)
            FETCH: begin
               if (rom_valid) begin
                  ir <= rom_data[7:0];
                  pc <= pc + AW'(1);
               end
            end
            OPND: begin
               if (rom_valid) begin
                  opnd <= rom_data;
                  pc   <= pc + AW'(1);
               end
            end
            MEMRD: begin
               if (ram_ready) opnd <= ram_rdata;
            end
            EXEC: begin
               if (mode != MODE_NOP) begin
                  res <= result;
                  if (src == SRC_ADD || src == SRC_SUB)
                     c <= aluC;
                  if (mode == MODE_OUT)
                     outData <= result;
                  // jump conditions see a and c from before this cycle
                  unique case (dst)
                     DST_A:   a <= result;
                     DST_B:   b <= result;
                     DST_X:   x <= result;
                     DST_Q:   q <= result;
                     DST_RAM: ;
                     DST_PC:  pc <= pcTgt;
                     DST_PCZ: if (a == '0) pc <= pcTgt;
                     DST_PCC: if (c) pc <= pcTgt;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

   assign rom_addr   = pc;
   assign ram_addr   = RAW'(x);
   assign ram_wdata  = res;
   assign ram_re     = (state == MEMRD);
   assign ram_we     = (state == MEMWR);
   assign out_data   = outData;
   assign out_strobe = (state == EXEC) && (mode == MODE_OUT);
   assign halted     = (state == HALT);
   assign pc_dbg     = pc;
   assign a_dbg      = a;

endmodule

// File: tb/tb_nic_cpu_core.sv
// tb_nic_cpu_core: directed tables, corner sequences and random programs
// checked against an instruction-level interpreter of the CPU.
module tb_nic_cpu_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- DW=8 instance ----------------
   logic        reset8 = 1'b0;
   logic [7:0]  romAddr8, romData8, ramAddr8, ramWdata8, ramRdata8;
   logic        romValid8, ramRe8, ramWe8, ramReady8;
   logic [7:0]  outData8, pcDbg8, aDbg8;
   logic        outStrobe8, halted8;

   logic [7:0]  rom8 [256];
   logic [7:0]  ram8 [256];
   logic [7:0]  ramSeed [256];
   logic        loadRam = 1'b0;
   int          ramDelay = 0;
   int          waitCnt = 0;
   logic        randMode = 1'b0;
   logic        manValid = 1'b1;
   logic        rndValid = 1'b1;

   assign romData8  = rom8[romAddr8];
   assign romValid8 = randMode ? rndValid : manValid;
   assign ramRdata8 = ram8[ramAddr8];
   assign ramReady8 = (ramRe8 || ramWe8) && (waitCnt >= ramDelay);

   always @(posedge clk) begin
      if (loadRam)
         for (int i = 0; i < 256; i++) ram8[i] <= ramSeed[i];
      else if (ramWe8 && ramReady8)
         ram8[ramAddr8] <= ramWdata8;
      if ((ramRe8 || ramWe8) && !ramReady8) waitCnt <= waitCnt + 1;
      else waitCnt <= 0;
   end

   always @(negedge clk) rndValid <= ($urandom % 4) != 0;

   logic [7:0] outQ [$];
   bit         pendOut = 0;
   int         weCyc = 0;
   int         reCyc = 0;
   always @(negedge clk) begin
      if (pendOut) outQ.push_back(outData8);
      pendOut = outStrobe8;
      if (ramWe8) weCyc++;
      if (ramRe8) reCyc++;
   end

   nic_cpu_core #(.DW(8), .AW(8), .RAW(8)) dut8 (
      .clk       (clk),
      .reset     (reset8),
      .rom_addr  (romAddr8),
      .rom_data  (romData8),
      .rom_valid (romValid8),
      .ram_addr  (ramAddr8),
      .ram_wdata (ramWdata8),
      .ram_re    (ramRe8),
      .ram_we    (ramWe8),
      .ram_rdata (ramRdata8),
      .ram_ready (ramReady8),
      .out_data  (outData8),
      .out_strobe(outStrobe8),
      .halted    (halted8),
      .pc_dbg    (pcDbg8),
      .a_dbg     (aDbg8)
   );

   // ---------------- DW=16 AW=12 instance ----------------
   logic        reset16 = 1'b0;
   logic [11:0] romAddr16, pcDbg16;
   logic [15:0] romData16, ramWdata16, outData16, aDbg16;
   logic [7:0]  ramAddr16;
   logic        ramRe16, ramWe16, outStrobe16, halted16;
   logic [15:0] rom16 [4096];
   logic        romValid16 = 1'b1;
   logic [15:0] ramRdata16 = '0;
   logic        ramReady16;

   assign romData16  = rom16[romAddr16];
   assign ramReady16 = ramRe16 || ramWe16;

   nic_cpu_core #(.DW(16), .AW(12), .RAW(8)) dut16 (
      .clk       (clk),
      .reset     (reset16),
      .rom_addr  (romAddr16),
      .rom_data  (romData16),
      .rom_valid (romValid16),
      .ram_addr  (ramAddr16),
      .ram_wdata (ramWdata16),
      .ram_re    (ramRe16),
      .ram_we    (ramWe16),
      .ram_rdata (ramRdata16),
      .ram_ready (ramReady16),
      .out_data  (outData16),
      .out_strobe(outStrobe16),
      .halted    (halted16),
      .pc_dbg    (pcDbg16),
      .a_dbg     (aDbg16)
   );

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic clearRom();
      for (int i = 0; i < 256; i++) rom8[i] = 8'h8D;
   endtask

   task automatic startProg();
      reset8 = 1'b1;
      loadRam = 1'b1;
      @(posedge clk);
      #1 loadRam = 1'b0;
      @(negedge clk);
      reset8 = 1'b0;
   endtask

   task automatic waitHalt(input string nm, input int budget);
      bit done = 0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         done = halted8;
      end
      chk(nm, 32'(done), 32'd1);
   endtask

   // ---------------- reference interpreter ----------------
   logic [7:0] mRam [256];
   logic [7:0] mOut [$];
   logic [7:0] mOutData, mA, mPc;

   task automatic model();
      logic [7:0] a = 0, b = 0, x = 0, q = 0, pc = 0;
      logic [7:0] ir, opnd, res;
      logic [2:0] s, d;
      logic [1:0] m;
      logic       c = 0;
      logic       cOld, zOld;
      mOut.delete();
      mOutData = 0;
      for (int step = 0; step < 300; step++) begin
         ir = rom8[pc];
         pc = pc + 1;
         s = ir[7:5];
         d = ir[4:2];
         m = ir[1:0];
         opnd = 0;
         if (s == 0) begin
            opnd = rom8[pc];
            pc = pc + 1;
         end else if (s == 1) opnd = mRam[x];
         case (s)
            0, 1: res = opnd;
            2: res = a + b;
            3: res = a - b;
            4: res = a;
            5: res = b;
            6: res = x;
            default: res = q;
         endcase
         cOld = c;
         zOld = (a == 0);
         if (m != 3) begin
            if (s == 2) c = (int'(a) + int'(b)) > 255;
            if (s == 3) c = (a >= b);
            if (m == 2) begin
               mOut.push_back(res);
               mOutData = res;
            end
            case (d)
               0: a = res;
               1: b = res;
               2: x = res;
               3: q = res;
               4: mRam[x] = res;
               5: pc = res;
               6: if (zOld) pc = res;
               default: if (cOld) pc = res;
            endcase
         end
         if (m == 1) break;
      end
      mA = a;
      mPc = pc;
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      bit         isSub;
      logic [7:0] expA;
      logic [7:0] expPc;
   } vecT;
   vecT vecs [8];

   initial begin
      int base, outBase, bad, n, addr, we0, re0;
      logic [2:0] src, dst;
      logic [1:0] md;

      vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 8'h41};
      vecs[1] = '{8'h80, 8'h80, 1'b0, 8'h00, 8'h41};
      vecs[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 8'h08};
      vecs[3] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 8'h08};
      vecs[4] = '{8'h05, 8'h03, 1'b1, 8'h02, 8'h41};
      vecs[5] = '{8'h03, 8'h05, 1'b1, 8'hFE, 8'h08};
      vecs[6] = '{8'h07, 8'h07, 1'b1, 8'h00, 8'h41};
      vecs[7] = '{8'h00, 8'hFF, 1'b1, 8'h01, 8'h08};
      for (int i = 0; i < 256; i++) ramSeed[i] = 8'h00;
      clearRom();

      // reset state
      #2 reset8 = 1'b1;
      #1;
      chk("rst_pc", 32'(pcDbg8), 0);
      chk("rst_a", 32'(aDbg8), 0);
      chk("rst_out", 32'(outData8), 0);
      chk("rst_ctl", {28'd0, outStrobe8, ramRe8, ramWe8, halted8}, 0);

      // arithmetic table; carry observed through a jump-if-carry
      foreach (vecs[k]) begin
         clearRom();
         rom8[0] = 8'h00; rom8[1] = vecs[k].a;
         rom8[2] = 8'h04; rom8[3] = vecs[k].b;
         rom8[4] = vecs[k].isSub ? 8'h60 : 8'h40;
         rom8[5] = 8'h1C; rom8[6] = 8'h40;
         startProg();
         waitHalt("tbl_halt", 200);
         chk("tbl_a", 32'(aDbg8), 32'(vecs[k].expA));
         chk("tbl_pc", 32'(pcDbg8), 32'(vecs[k].expPc));
      end

      // 5 + 3 sent to the output port, then halt
      clearRom();
      rom8[0] = 8'h00; rom8[1] = 8'h05;
      rom8[2] = 8'h04; rom8[3] = 8'h03;
      rom8[4] = 8'h42;
      outBase = outQ.size();
      startProg();
      waitHalt("out_halt", 200);
      chk("out_data", 32'(outData8), 32'h08);
      chk("out_strobes", 32'(outQ.size() - outBase), 1);
      chk("out_pc", 32'(pcDbg8), 6);
      chk("out_a", 32'(aDbg8), 32'h08);

      // wrap to zero then taken jump-if-zero, then jump-if-carry
      clearRom();
      rom8[0] = 8'h00; rom8[1] = 8'hFF;
      rom8[2] = 8'h04; rom8[3] = 8'h01;
      rom8[4] = 8'h40;
      rom8[5] = 8'h18; rom8[6] = 8'h20;
      rom8[8'h20] = 8'h1C; rom8[8'h21] = 8'h30;
      startProg();
      begin
         bit seen = 0;
         for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = (pcDbg8 == 8'h20);
         end
         chk("jz_taken", 32'(seen), 1);
      end
      waitHalt("jz_halt", 200);
      chk("jz_a", 32'(aDbg8), 0);
      chk("jc_pc", 32'(pcDbg8), 32'h31);

      // RAM write then read back with slow ready
      clearRom();
      rom8[0] = 8'h08; rom8[1] = 8'h10;
      rom8[2] = 8'h00; rom8[3] = 8'h5A;
      rom8[4] = 8'h90;
      rom8[5] = 8'h24;
      rom8[6] = 8'h00; rom8[7] = 8'h00;
      rom8[8] = 8'hA1;
      ramDelay = 3;
      startProg();
      we0 = weCyc;
      re0 = reCyc;
      waitHalt("mem_halt", 300);
      chk("mem_we_cyc", 32'(weCyc - we0), 4);
      chk("mem_re_cyc", 32'(reCyc - re0), 4);
      chk("mem_ram", 32'(ram8[8'h10]), 32'h5A);
      chk("mem_a", 32'(aDbg8), 32'h5A);
      chk("mem_pc", 32'(pcDbg8), 9);
      ramDelay = 0;

      // rom_valid stall during the operand fetch
      clearRom();
      rom8[0] = 8'h01; rom8[1] = 8'h77;
      startProg();
      @(posedge clk);
      #1 manValid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("stall_pc", 32'(pcDbg8), 1);
      chk("stall_a", 32'(aDbg8), 0);
      manValid = 1'b1;
      waitHalt("stall_halt", 50);
      chk("stall_final_a", 32'(aDbg8), 32'h77);
      chk("stall_final_pc", 32'(pcDbg8), 2);

      // reset during a pending RAM write
      clearRom();
      rom8[0] = 8'h00; rom8[1] = 8'h33;
      rom8[2] = 8'h91;
      ramSeed[0] = 8'hEE;
      ramDelay = 10;
      startProg();
      begin
         bit seen = 0;
         for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = ramWe8;
         end
         chk("rstw_we_seen", 32'(seen), 1);
      end
      reset8 = 1'b1;
      #1;
      chk("rstw_we", 32'(ramWe8), 0);
      chk("rstw_a", 32'(aDbg8), 0);
      chk("rstw_pc", 32'(pcDbg8), 0);
      chk("rstw_ram", 32'(ram8[0]), 32'hEE);
      ramDelay = 0;
      @(negedge clk);
      reset8 = 1'b0;
      @(posedge clk);
      #1 chk("rstw_refetch", 32'(pcDbg8), 1);
      waitHalt("rstw_halt", 50);
      chk("rstw_ram_final", 32'(ram8[0]), 32'h33);
      ramSeed[0] = 8'h00;

      // random programs against the interpreter
      randMode = 1'b1;
      for (int p = 0; p < 25; p++) begin
         clearRom();
         n = $urandom_range(16, 6);
         addr = 0;
         for (int i = 0; i < n; i++) begin
            src = 3'($urandom % 8);
            dst = 3'($urandom % 5);
            md = (($urandom % 3) == 0) ? 2'd2 :
                 ((($urandom % 4) == 0) ? 2'd3 : 2'd0);
            if (i == n - 1) md = 2'd1;
            rom8[addr] = {src, dst, md};
            addr++;
            if (src == 0) begin
               rom8[addr] = 8'($urandom);
               addr++;
            end
         end
         for (int i = 0; i < 256; i++) begin
            ramSeed[i] = 8'($urandom);
            mRam[i] = ramSeed[i];
         end
         ramDelay = $urandom_range(2, 0);
         model();
         outBase = outQ.size();
         startProg();
         waitHalt("rnd_halt", 2000);
         chk("rnd_a", 32'(aDbg8), 32'(mA));
         chk("rnd_pc", 32'(pcDbg8), 32'(mPc));
         chk("rnd_out", 32'(outData8), 32'(mOutData));
         chk("rnd_nout", 32'(outQ.size() - outBase), 32'(mOut.size()));
         bad = 0;
         base = outQ.size() - outBase;
         for (int i = 0; i < base && i < mOut.size(); i++)
            if (outQ[outBase + i] !== mOut[i]) bad++;
         for (int i = 0; i < 256; i++)
            if (ram8[i] !== mRam[i]) bad++;
         chk("rnd_data", 32'(bad), 0);
      end
      randMode = 1'b0;

      // 16-bit subtract and PC wrap at the top of a 12-bit space
      for (int i = 0; i < 4096; i++) rom16[i] = 16'h008D;
      rom16[0] = 16'h0000; rom16[1] = 16'h8000;
      rom16[2] = 16'h0004; rom16[3] = 16'h0001;
      rom16[4] = 16'h0060;
      rom16[5] = 16'h001C; rom16[6] = 16'h0FFF;
      reset16 = 1'b1;
      @(negedge clk);
      reset16 = 1'b0;
      begin
         bit done = 0;
         for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = halted16;
         end
         chk("w16_halt", 32'(done), 1);
      end
      chk("w16_a", 32'(aDbg16), 32'h7FFF);
      chk("w16_pc", 32'(pcDbg16), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
